simple_dut_checker: RTL and testbench



---
 rtl/simple_dut_checker_if.sv | 28 ++
 rtl/simple_dut_checker.sv | 158 +++++++++++++++
 tb/tb_simple_dut_checker.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_dut_checker_if.sv
// Stream and status bundle between the simpleDut output stream and its checker.
// The checker takes the slave view; the bench or neighbouring logic takes the master view.
interface simple_dut_checker_if #(
   parameter int ERR_W = 16
);
   logic             i_enable;
   logic             i_clear;
   logic             i_bitSignal1;
   logic             i_bitSignal2;
   logic [31:0]      i_bit32Signal1;
   logic [7:0]       i_bit8Signal2;
   logic             o_locked;
   logic             o_seqErr;
   logic             o_toggleErr;
   logic [ERR_W-1:0] o_errCount;
   logic [31:0]      o_sampleCount;
   logic [31:0]      o_signature;

   modport master (
      output i_enable, i_clear, i_bitSignal1, i_bitSignal2, i_bit32Signal1, i_bit8Signal2,
      input  o_locked, o_seqErr, o_toggleErr, o_errCount, o_sampleCount, o_signature
   );

   modport slave (
      input  i_enable, i_clear, i_bitSignal1, i_bitSignal2, i_bit32Signal1, i_bit8Signal2,
      output o_locked, o_seqErr, o_toggleErr, o_errCount, o_sampleCount, o_signature
   );
endinterface

// File: rtl/simple_dut_checker.sv
// Locks onto the toggle-bit / incrementing-counter stream, then flags breaks, counts errors and signs data.
// Every status output appears one cycle after its sampling edge; no backpressure, one sample per enabled clock.
module simple_dut_checker #(
   parameter int LOCK_CNT = 4,
   parameter int MAX_MISS = 2,
   parameter int ERR_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   simple_dut_checker_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             prev_valid_q, prev_valid_d;
   logic             prev_a_q;
   logic             prev_b_q;
   logic [7:0]       prev_cnt_q;
   logic [7:0]       good_run_q, good_run_d;
   logic [7:0]       miss_run_q, miss_run_d;
   logic             locked_q, locked_d;
   logic             seq_err_q, seq_err_d;
   logic             tog_err_q, tog_err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [31:0]      sample_cnt_q, sample_cnt_d;
   logic [31:0]      sig_q, sig_d;

   logic             seq_ok;
   logic             tog_ok;
   logic             good;
   logic [7:0]       good_run_inc;
   logic [7:0]       miss_run_inc;

   // The 8-bit add wraps naturally, so 255 -> 0 counts as in sequence.
   assign seq_ok       = (bus.i_bit8Signal2 == 8'(prev_cnt_q + 8'd1));
   assign tog_ok       = (bus.i_bitSignal1 != prev_a_q) && (bus.i_bitSignal2 != prev_b_q);
   assign good         = prev_valid_q && seq_ok && tog_ok;
   assign good_run_inc = 8'(good_run_q + 8'd1);
   assign miss_run_inc = 8'(miss_run_q + 8'd1);

   always_comb begin
      state_d      = state_q;
      prev_valid_d = prev_valid_q;
      good_run_d   = good_run_q;
      miss_run_d   = miss_run_q;
      locked_d     = locked_q;
      seq_err_d    = 1'b0;
      tog_err_d    = 1'b0;
      err_cnt_d    = err_cnt_q;
      sample_cnt_d = sample_cnt_q;
      sig_d        = sig_q;

      if (!bus.i_enable) begin
         state_d      = IDLE;
         prev_valid_d = 1'b0;
         good_run_d   = 8'd0;
         miss_run_d   = 8'd0;
         locked_d     = 1'b0;
      end else begin
         prev_valid_d = 1'b1;
         unique case (state_q)
            IDLE: begin
               // First sample only seeds the prev registers.
               state_d    = ACQUIRE;
               good_run_d = 8'd0;
            end
            ACQUIRE: begin
               if (good) begin
                  good_run_d = good_run_inc;
                  if (good_run_inc == 8'(LOCK_CNT)) begin
                     state_d    = LOCKED;
                     miss_run_d = 8'd0;
                     sig_d      = 32'd0;
                     locked_d   = 1'b1;
                  end
               end else begin
                  good_run_d = 8'd0;
               end
            end
            LOCKED: begin
               sample_cnt_d = sample_cnt_q + 32'd1;
               sig_d        = {sig_q[30:0], sig_q[31]} ^ bus.i_bit32Signal1;
               if (good) begin
                  miss_run_d = 8'd0;
               end else begin
                  seq_err_d  = !seq_ok;
                  tog_err_d  = !tog_ok;
                  err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
                  miss_run_d = miss_run_inc;
                  if (miss_run_inc == 8'(MAX_MISS)) begin
                     state_d    = ACQUIRE;
                     good_run_d = 8'd0;
                     miss_run_d = 8'd0;
                     locked_d   = 1'b0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // Clear wins over any same-cycle statistics update but leaves the FSM alone.
      if (bus.i_clear) begin
         err_cnt_d    = '0;
         sample_cnt_d = 32'd0;
         sig_d        = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         prev_valid_q <= 1'b0;
         prev_a_q     <= 1'b0;
         prev_b_q     <= 1'b0;
         prev_cnt_q   <= 8'd0;
         good_run_q   <= 8'd0;
         miss_run_q   <= 8'd0;
         locked_q     <= 1'b0;
         seq_err_q    <= 1'b0;
         tog_err_q    <= 1'b0;
         err_cnt_q    <= '0;
         sample_cnt_q <= 32'd0;
         sig_q        <= 32'd0;
      end else begin
         state_q      <= state_d;
         prev_valid_q <= prev_valid_d;
         good_run_q   <= good_run_d;
         miss_run_q   <= miss_run_d;
         locked_q     <= locked_d;
         seq_err_q    <= seq_err_d;
         tog_err_q    <= tog_err_d;
         err_cnt_q    <= err_cnt_d;
         sample_cnt_q <= sample_cnt_d;
         sig_q        <= sig_d;
         if (bus.i_enable) begin
            prev_a_q   <= bus.i_bitSignal1;
            prev_b_q   <= bus.i_bitSignal2;
            prev_cnt_q <= bus.i_bit8Signal2;
         end
      end
   end

   assign bus.o_locked      = locked_q;
   assign bus.o_seqErr      = seq_err_q;
   assign bus.o_toggleErr   = tog_err_q;
   assign bus.o_errCount    = err_cnt_q;
   assign bus.o_sampleCount = sample_cnt_q;
   assign bus.o_signature   = sig_q;

endmodule

// File: tb/tb_simple_dut_checker.sv
// Directed bench for simple_dut_checker: a sample-level model is checked every cycle, plus literal spot checks.
module tb_simple_dut_checker;
   localparam int LOCK_CNT = 4;
   localparam int MAX_MISS = 2;
   localparam int ERR_W    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   simple_dut_checker_if #(.ERR_W(ERR_W)) bus();

   simple_dut_checker #(.LOCK_CNT(LOCK_CNT), .MAX_MISS(MAX_MISS), .ERR_W(ERR_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: mode 0 = waiting for first sample, 1 = hunting, 2 = locked.
   int          m_mode = 0;
   bit          m_pv = 0;
   bit          m_pa = 0, m_pb = 0;
   int          m_pc = 0;
   int          m_good = 0, m_miss = 0;
   bit          e_locked = 0, e_seq = 0, e_tog = 0;
   int unsigned e_err = 0, e_cnt = 0;
   logic [31:0] e_sig = 32'd0;

   task automatic model(bit r, bit e, bit c, bit a, bit b, logic [31:0] d, logic [7:0] c8);
      bit sok, tok, g;
      e_seq = 0;
      e_tog = 0;
      if (r) begin
         m_mode = 0; m_pv = 0; m_pa = 0; m_pb = 0; m_pc = 0; m_good = 0; m_miss = 0;
         e_locked = 0; e_err = 0; e_cnt = 0; e_sig = 32'd0;
         return;
      end
      if (!e) begin
         m_mode = 0; m_pv = 0; m_good = 0; m_miss = 0; e_locked = 0;
      end else begin
         sok = (int'(c8) == (m_pc + 1) % 256);
         tok = (a != m_pa) && (b != m_pb);
         g   = m_pv && sok && tok;
         if (m_mode == 0) begin
            m_mode = 1;
            m_good = 0;
         end else if (m_mode == 1) begin
            m_good = g ? m_good + 1 : 0;
            if (m_good == LOCK_CNT) begin
               m_mode = 2; m_miss = 0; e_sig = 32'd0; e_locked = 1;
            end
         end else begin
            e_cnt = e_cnt + 1;
            e_sig = ((e_sig << 1) | (e_sig >> 31)) ^ d;
            if (g) m_miss = 0;
            else begin
               e_seq = !sok;
               e_tog = !tok;
               if (e_err < (2 ** ERR_W) - 1) e_err = e_err + 1;
               m_miss = m_miss + 1;
               if (m_miss == MAX_MISS) begin
                  m_mode = 1; m_good = 0; m_miss = 0; e_locked = 0;
               end
            end
         end
         m_pv = 1; m_pa = a; m_pb = b; m_pc = int'(c8);
      end
      if (c) begin
         e_err = 0; e_cnt = 0; e_sig = 32'd0;
      end
   endtask

   bit cmp_on = 0;

   always @(posedge clk) begin
      #1;
      if (cmp_on) begin
         chk("locked",  32'(bus.o_locked),    32'(e_locked));
         chk("seqErr",  32'(bus.o_seqErr),    32'(e_seq));
         chk("togErr",  32'(bus.o_toggleErr), 32'(e_tog));
         chk("errCnt",  32'(bus.o_errCount),  e_err);
         chk("sampCnt", bus.o_sampleCount,    e_cnt);
         chk("sig",     bus.o_signature,      e_sig);
      end
   end

   bit         la = 0, lb = 0;
   logic [7:0] lc = 8'd0;

   task automatic step(bit r, bit e, bit c, bit a, bit b, logic [31:0] d, logic [7:0] c8);
      rst                = r;
      bus.i_enable       = e;
      bus.i_clear        = c;
      bus.i_bitSignal1   = a;
      bus.i_bitSignal2   = b;
      bus.i_bit32Signal1 = d;
      bus.i_bit8Signal2  = c8;
      model(r, e, c, a, b, d, c8);
      la = a; lb = b; lc = c8;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] dflt(logic [7:0] c8);
      return {8'h5A, c8, 8'hC3, ~c8};
   endfunction

   task automatic clean_d(logic [31:0] d);
      step(0, 1, 0, !la, !lb, d, 8'(lc + 8'd1));
   endtask

   task automatic clean();
      clean_d(dflt(8'(lc + 8'd1)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_enable = 0; bus.i_clear = 0; bus.i_bitSignal1 = 0; bus.i_bitSignal2 = 0;
      bus.i_bit32Signal1 = 32'd0; bus.i_bit8Signal2 = 8'd0;
      @(negedge clk);
      cmp_on = 1;

      // Reset
      step(1, 0, 0, 0, 0, 32'd0, 8'd0);
      step(1, 0, 0, 0, 0, 32'd0, 8'd0);
      chk("rst_locked", 32'(bus.o_locked), 32'd0);
      chk("rst_err", 32'(bus.o_errCount), 32'd0);
      chk("rst_cnt", bus.o_sampleCount, 32'd0);
      chk("rst_sig", bus.o_signature, 32'd0);

      // Clean stream: capture + 4 good locks on the 5th edge
      step(0, 1, 0, 0, 0, dflt(8'd0), 8'd0);
      repeat (3) clean();
      chk("lock_not_yet", 32'(bus.o_locked), 32'd0);
      clean();
      chk("lock_5th", 32'(bus.o_locked), 32'd1);
      repeat (5) clean();
      chk("cnt_after10", bus.o_sampleCount, 32'd5);
      chk("err_clean", 32'(bus.o_errCount), 32'd0);

      // Counter wrap 253..1
      while (lc != 8'd252) clean();
      for (int i = 0; i < 5; i++) begin
         clean();
         chk("wrap_seq", 32'(bus.o_seqErr), 32'd0);
      end
      chk("wrap_err", 32'(bus.o_errCount), 32'd0);

      // Single counter jump 10,11,40,41,42
      while (lc != 8'd9) clean();
      clean();
      clean();
      lc = 8'd39;
      clean();
      chk("jump_seq", 32'(bus.o_seqErr), 32'd1);
      chk("jump_tog", 32'(bus.o_toggleErr), 32'd0);
      chk("jump_err", 32'(bus.o_errCount), 32'd1);
      chk("jump_lock", 32'(bus.o_locked), 32'd1);
      clean();
      chk("jump_seq_after", 32'(bus.o_seqErr), 32'd0);
      clean();

      // Clear, then hold bit B for two samples to drop lock
      step(0, 1, 1, !la, !lb, dflt(8'(lc + 8'd1)), 8'(lc + 8'd1));
      chk("clr_err", 32'(bus.o_errCount), 32'd0);
      step(0, 1, 0, !la, lb, dflt(8'(lc + 8'd1)), 8'(lc + 8'd1));
      chk("hold1_tog", 32'(bus.o_toggleErr), 32'd1);
      chk("hold1_lock", 32'(bus.o_locked), 32'd1);
      step(0, 1, 0, !la, lb, dflt(8'(lc + 8'd1)), 8'(lc + 8'd1));
      chk("hold2_tog", 32'(bus.o_toggleErr), 32'd1);
      chk("hold2_err", 32'(bus.o_errCount), 32'd2);
      chk("hold2_lock", 32'(bus.o_locked), 32'd0);
      repeat (3) clean();
      chk("relock_not_yet", 32'(bus.o_locked), 32'd0);
      clean();
      chk("relock", 32'(bus.o_locked), 32'd1);

      // Signature from zero: 1, 2, 4
      clean_d(32'h1);
      chk("sig_1", bus.o_signature, 32'h1);
      clean_d(32'h2);
      chk("sig_2", bus.o_signature, 32'h0);
      clean_d(32'h4);
      chk("sig_3", bus.o_signature, 32'h4);

      // Clear on the same cycle as a counter error
      lc = 8'(lc + 8'd5);
      step(0, 1, 1, !la, !lb, dflt(8'(lc + 8'd1)), 8'(lc + 8'd1));
      chk("clr_same_err", 32'(bus.o_errCount), 32'd0);
      chk("clr_same_seq", 32'(bus.o_seqErr), 32'd1);
      chk("clr_same_cnt", bus.o_sampleCount, 32'd0);
      clean();

      // Saturation of the error counter (4 bits here)
      for (int i = 0; i < 20; i++) begin
         lc = 8'(lc + 8'd3);
         clean();
         clean();
      end
      chk("sat_err", 32'(bus.o_errCount), 32'd15);
      chk("sat_lock", 32'(bus.o_locked), 32'd1);

      // Enable drop mid-LOCKED with an otherwise bad sample
      step(0, 0, 0, la, lb, 32'hDEAD_BEEF, 8'(lc + 8'd9));
      chk("dis_lock", 32'(bus.o_locked), 32'd0);
      chk("dis_seq", 32'(bus.o_seqErr), 32'd0);
      chk("dis_err", 32'(bus.o_errCount), 32'd15);
      step(0, 1, 0, la, lb, dflt(8'd100), 8'd100);
      repeat (4) clean();
      chk("reen_lock", 32'(bus.o_locked), 32'd1);

      // Reset mid-LOCKED with a bad sample present
      step(1, 1, 0, la, lb, 32'h1234_5678, 8'(lc + 8'd7));
      chk("rst_mid_lock", 32'(bus.o_locked), 32'd0);
      chk("rst_mid_seq", 32'(bus.o_seqErr), 32'd0);
      chk("rst_mid_tog", 32'(bus.o_toggleErr), 32'd0);
      chk("rst_mid_err", 32'(bus.o_errCount), 32'd0);
      chk("rst_mid_cnt", bus.o_sampleCount, 32'd0);
      step(0, 0, 0, 0, 0, 32'd0, 8'd0);

      cmp_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
